// File: rtl/mips_pkg.sv
// Shared fetch-stage constants and the next-PC source encoding.
package mips_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH   = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;
  localparam int unsigned DEFAULT_INCREMENT    = 4;
  localparam int unsigned DEFAULT_RAS_DEPTH    = 4;

  // Next-PC source, listed in decreasing priority.
  typedef enum logic [2:0] {
    SRC_EXC,
    SRC_HOLD,
    SRC_RAS,
    SRC_JUMP,
    SRC_SEQ
  } next_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;

  assign top   = mem[ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Pointer, occupancy and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop && empty) underflow <= 1'b1;
      if (push && pop && !empty) begin
        // Replace-in-place: occupancy and pointer unchanged.
      end else if (push) begin
        ptr <= ptr + PTR_W'(1);
        if (full) overflow <= 1'b1;
        else      count    <= count + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr   <= ptr - PTR_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

  // Entry storage carries no reset; empty slots are never read out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push && pop && !empty) mem[ptr]              <= data_in;
      else if (push)             mem[ptr + PTR_W'(1)]  <= data_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch program counter: exception / RAS-return / jump / sequential next-PC select with EPC capture.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0]   EXC_VECTOR   = ADDR_WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned             INCREMENT    = DEFAULT_INCREMENT,
  parameter int unsigned             RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  control_stall,
  input  logic                  control_use_npc,
  input  logic [ADDR_WIDTH-1:0] data_jump_address,
  input  logic                  control_exception,
  input  logic                  control_ras_push,
  input  logic                  control_ras_pop,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [ADDR_WIDTH-1:0] data_npc,
  output logic [ADDR_WIDTH-1:0] data_epc,
  output logic                  status_misaligned,
  output logic                  status_ras_empty,
  output logic                  status_ras_full,
  output logic                  status_ras_overflow,
  output logic                  status_ras_underflow
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] ras_top;
  logic [CNT_W-1:0]      ras_count;
  logic                  ras_has_entry;
  logic                  push_en;
  logic                  pop_en;
  next_src_e             src;

  assign data_npc          = instruction_address + ADDR_WIDTH'(INCREMENT);
  assign status_misaligned = (instruction_address[1:0] != 2'b00);

  // Stall and exception both freeze the stack.
  assign push_en       = control_ras_push && !control_stall && !control_exception;
  assign pop_en        = control_ras_pop  && !control_stall && !control_exception;
  assign ras_has_entry = (ras_count != '0);

  pc_ras #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push_en),
    .pop       (pop_en),
    .data_in   (data_npc),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (status_ras_empty),
    .full      (status_ras_full),
    .overflow  (status_ras_overflow),
    .underflow (status_ras_underflow)
  );

  // Next-PC source priority.
  always_comb begin
    src = SRC_SEQ;
    if (control_exception)             src = SRC_EXC;
    else if (control_stall)            src = SRC_HOLD;
    else if (pop_en && ras_has_entry)  src = SRC_RAS;
    else if (!control_use_npc)         src = SRC_JUMP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_address <= RESET_VECTOR;
      data_epc            <= '0;
    end else begin
      case (src)
        SRC_EXC: begin
          instruction_address <= EXC_VECTOR;
          data_epc            <= instruction_address;
        end
        SRC_HOLD: instruction_address <= instruction_address;
        SRC_RAS:  instruction_address <= ras_top;
        SRC_JUMP: instruction_address <= data_jump_address;
        default:  instruction_address <= data_npc;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer with hand-computed expected PC, EPC and RAS status.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        control_stall;
  logic        control_use_npc;
  logic [31:0] data_jump_address;
  logic        control_exception;
  logic        control_ras_push;
  logic        control_ras_pop;
  logic [31:0] instruction_address;
  logic [31:0] data_npc;
  logic [31:0] data_epc;
  logic        status_misaligned;
  logic        status_ras_empty;
  logic        status_ras_full;
  logic        status_ras_overflow;
  logic        status_ras_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock                (clock),
    .reset                (reset),
    .control_stall        (control_stall),
    .control_use_npc      (control_use_npc),
    .data_jump_address    (data_jump_address),
    .control_exception    (control_exception),
    .control_ras_push     (control_ras_push),
    .control_ras_pop      (control_ras_pop),
    .instruction_address  (instruction_address),
    .data_npc             (data_npc),
    .data_epc             (data_epc),
    .status_misaligned    (status_misaligned),
    .status_ras_empty     (status_ras_empty),
    .status_ras_full      (status_ras_full),
    .status_ras_overflow  (status_ras_overflow),
    .status_ras_underflow (status_ras_underflow)
  );

  typedef struct {
    logic        rst, stall, npc;
    logic [31:0] jmp;
    logic        exc, push, pop;
    logic [31:0] pc, epc;
    logic        emp, ful, ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stall, logic npc, logic [31:0] jmp,
                              logic exc, logic push, logic pop,
                              logic [31:0] pc, logic [31:0] epc,
                              logic emp, logic ful, logic ovf, logic unf);
    vec_t v;
    v.rst = rst; v.stall = stall; v.npc = npc; v.jmp = jmp;
    v.exc = exc; v.push = push; v.pop = pop;
    v.pc = pc; v.epc = epc; v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=0x%08h want=0x%08h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic run(input vec_t v, input int idx);
    logic [31:0] exp_npc;
    reset             = v.rst;
    control_stall     = v.stall;
    control_use_npc   = v.npc;
    data_jump_address = v.jmp;
    control_exception = v.exc;
    control_ras_push  = v.push;
    control_ras_pop   = v.pop;
    @(posedge clock);
    #1;
    exp_npc = v.pc + 32'd4;
    chk("pc",        idx, instruction_address,          v.pc);
    chk("npc",       idx, data_npc,                     exp_npc);
    chk("epc",       idx, data_epc,                     v.epc);
    chk("misalign",  idx, 32'(status_misaligned),       32'(v.pc[1:0] != 2'b00));
    chk("empty",     idx, 32'(status_ras_empty),        32'(v.emp));
    chk("full",      idx, 32'(status_ras_full),         32'(v.ful));
    chk("overflow",  idx, 32'(status_ras_overflow),     32'(v.ovf));
    chk("underflow", idx, 32'(status_ras_underflow),    32'(v.unf));
  endtask

  initial begin
    //                rst st npc jmp           ex pu po  pc            epc       emp fu ov un
    // legacy sequence
    vecs.push_back(mk(1, 0, 1, 32'h0,         0, 0, 0, 32'h0,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'h4,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'h8,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd15,        0, 0, 0, 32'd15,       32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'd19,       32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'd3,         0, 0, 0, 32'd3,        32'h0,    1, 0, 0, 0));
    // stall holds PC and freezes the stack
    vecs.push_back(mk(0, 0, 0, 32'h8,         0, 0, 0, 32'h8,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0,         0, 1, 0, 32'h8,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0,         0, 1, 0, 32'h8,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0,         0, 1, 0, 32'h8,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h999,       0, 0, 1, 32'h8,        32'h0,    1, 0, 0, 0));
    // call / return
    vecs.push_back(mk(0, 0, 0, 32'h100,       0, 0, 0, 32'h100,      32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h400,       0, 1, 0, 32'h400,      32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'h404,      32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'h408,      32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h104,      32'h0,    1, 0, 0, 0));
    // stack boundaries: five pushes, then five pops
    vecs.push_back(mk(0, 0, 0, 32'h10,        0, 0, 0, 32'h10,       32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h20,        0, 1, 0, 32'h20,       32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h30,        0, 1, 0, 32'h30,       32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h40,        0, 1, 0, 32'h40,       32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h50,        0, 1, 0, 32'h50,       32'h0,    0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h60,        0, 1, 0, 32'h60,       32'h0,    0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h54,       32'h0,    0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h44,       32'h0,    0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h34,       32'h0,    0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h24,       32'h0,    1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h28,       32'h0,    1, 0, 1, 1));
    // exception during stall with push/pop pending
    vecs.push_back(mk(0, 0, 0, 32'h200,       0, 1, 0, 32'h200,      32'h0,    0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 32'h0,         1, 1, 1, 32'h80,       32'h200,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h2C,       32'h200,  1, 0, 1, 1));
    // wrap, then reset with a populated stack and captured EPC
    vecs.push_back(mk(0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 32'h200, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'h0,        32'h200,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 1, 0, 32'h4,        32'h200,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 1, 0, 32'h8,        32'h200,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 1, 0, 32'hC,        32'h200,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0,         1, 0, 0, 32'h80,       32'hC,    0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 32'h0,         1, 1, 1, 32'h0,        32'h0,    1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 1, 32'h4,        32'h0,    1, 0, 0, 1));

    foreach (vecs[i]) run(vecs[i], i);

    // Push+pop on a non-empty stack returns the old top and replaces it with the new return address.
    run(mk(1, 0, 1, 32'h0,   0, 0, 0, 32'h0,   32'h0, 1, 0, 0, 0), 100);
    run(mk(0, 0, 1, 32'h0,   0, 1, 0, 32'h4,   32'h0, 0, 0, 0, 0), 101);
    run(mk(0, 0, 1, 32'h0,   0, 1, 1, 32'h4,   32'h0, 0, 0, 0, 0), 102);
    run(mk(0, 0, 1, 32'h0,   0, 0, 1, 32'h8,   32'h0, 1, 0, 0, 0), 103);
    // Push+pop on an empty stack: push lands, underflow flags, PC takes the jump.
    run(mk(0, 0, 0, 32'h300, 0, 1, 1, 32'h300, 32'h0, 0, 0, 0, 1), 104);
    run(mk(0, 0, 1, 32'h0,   0, 0, 1, 32'hC,   32'h0, 1, 0, 0, 1), 105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
